cpu_core_p: RTL and testbench

Parametrised multi-cycle CPU core, the successor to the fixed 8-bit cpu top. It integrates the control FSM, program counter, instruction register, register file, ALU and flags. Instruction memory is external, behind a req/ack handshake, so wait-state memories are supported. Beyond the previous generation it adds conditional branches on flags, immediate ops, CMP and HALT, and widths and register count are parameters.

---
 rtl/cpu_core_p_pkg.sv | 59 +++++
 rtl/cpu_core_p_alu.sv | 48 ++++
 rtl/cpu_core_p.sv | 159 +++++++++++++++
 tb/tb_cpu_core_p.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_p_pkg.sv
// Shared definitions for the parametrised multi-cycle core: opcodes, FSM
// encoding and instruction field positions.
package cpu_pkg_p;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BC   = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  // Instruction layout, MSB first: {opcode, rs, rt, rd, imm}.
  function automatic int instr_width(input int raw, input int dw);
    return 4 + 3 * raw + dw;
  endfunction

  function automatic int op_lsb(input int raw, input int dw);
    return dw + 3 * raw;
  endfunction

  function automatic int rs_lsb(input int raw, input int dw);
    return dw + 2 * raw;
  endfunction

  function automatic int rt_lsb(input int raw, input int dw);
    return dw + raw;
  endfunction

  function automatic int rd_lsb(input int raw, input int dw);
    return dw + 0 * raw;
  endfunction

  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  function automatic logic is_flag_op(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_ADDI) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/cpu_core_p_alu.sv
// Combinational ALU: result, zero/carry flags and whether this opcode
// is allowed to update the flag register.
module alu_p
  import cpu_pkg_p::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          c,
  output logic          upd_flags
);
  localparam int SW = $clog2(DW);

  logic [DW:0] sum_ab;
  logic [DW:0] diff_ab;
  logic [DW:0] sum_ai;

  // The extra top bit of the subtraction is the borrow, i.e. a < b.
  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_ai  = {1'b0, a} + {1'b0, imm};

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD:         begin result = sum_ab[DW-1:0];  c = sum_ab[DW];  end
      OP_SUB, OP_CMP: begin result = diff_ab[DW-1:0]; c = diff_ab[DW]; end
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_SHL:         result = a << imm[SW-1:0];
      OP_SHR:         result = a >> imm[SW-1:0];
      OP_LDI:         result = imm;
      OP_ADDI:        begin result = sum_ai[DW-1:0];  c = sum_ai[DW];  end
      OP_MOV:         result = a;
      default:        result = '0;
    endcase
    z         = (result == '0);
    upd_flags = is_flag_op(op);
  end

endmodule

// File: rtl/cpu_core_p.sv
// Parametrised multi-cycle core: FETCH -> DECODE -> EXEC -> (WB) -> FETCH,
// with an external instruction memory and a halt state left only by reset.
module cpu_core_p
  import cpu_pkg_p::*;
#(
  parameter int            DW       = 8,
  parameter int            NREG     = 16,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  localparam int           RAW      = $clog2(NREG),
  localparam int           IW       = instr_width(RAW, DW)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req,
  output logic [AW-1:0]  imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_rdata,
  output logic           wb_valid,
  output logic [RAW-1:0] wb_addr,
  output logic [DW-1:0]  wb_data,
  output logic           flag_zero,
  output logic           flag_carry,
  output logic           halted,
  output logic [AW-1:0]  pc
);
  localparam int OP_L = op_lsb(RAW, DW);
  localparam int RS_L = rs_lsb(RAW, DW);
  localparam int RT_L = rt_lsb(RAW, DW);
  localparam int RD_L = rd_lsb(RAW, DW);

  state_e         state, state_nx;
  logic           run;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  regs [NREG];
  logic [DW-1:0]  a_q, b_q;
  logic [AW-1:0]  pc_q;
  logic           z_q, c_q;

  logic [3:0]     op;
  logic [RAW-1:0] rs, rt, rd;
  logic [DW-1:0]  imm;
  logic [DW-1:0]  alu_res;
  logic           alu_z, alu_c, alu_upd;
  logic [AW-1:0]  target;
  logic           take_branch;
  logic           fetch_go;

  assign op  = ir[OP_L +: 4];
  assign rs  = ir[RS_L +: RAW];
  assign rt  = ir[RT_L +: RAW];
  assign rd  = ir[RD_L +: RAW];
  assign imm = ir[DW-1:0];

  if (AW <= DW) begin : g_tgt_trunc
    assign target = imm[AW-1:0];
  end else begin : g_tgt_ext
    assign target = {{(AW - DW){1'b0}}, imm};
  end

  alu_p #(.DW(DW)) u_alu (
    .op        (op),
    .a         (a_q),
    .b         (b_q),
    .imm       (imm),
    .result    (alu_res),
    .z         (alu_z),
    .c         (alu_c),
    .upd_flags (alu_upd)
  );

  always_comb begin
    case (op)
      OP_BZ:   take_branch = z_q;
      OP_BC:   take_branch = c_q;
      OP_JMP:  take_branch = 1'b1;
      default: take_branch = 1'b0;
    endcase
  end

  // Fetch handshake: imem_req stays high with a stable imem_addr until the
  // first cycle in which imem_ack is also high; that cycle transfers the word.
  // run keeps req low for the cycle following any reset edge.
  assign fetch_go = (state == S_FETCH) && run && imem_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (fetch_go) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (op == OP_HLT)         state_nx = S_HALT;
        else if (is_write_op(op)) state_nx = S_WB;
        else                      state_nx = S_FETCH;
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state == S_FETCH) && run;
    halted   = (state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pc_q     <= RESET_PC;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wb_valid <= (state == S_EXEC) && is_write_op(op);
      case (state)
        S_FETCH: if (fetch_go) ir <= imem_rdata;
        S_DECODE: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
        end
        S_EXEC: begin
          if (alu_upd) begin
            z_q <= alu_z;
            c_q <= alu_c;
          end
          if (is_write_op(op)) begin
            wb_addr <= rd;
            wb_data <= alu_res;
          end
          if (op != OP_HLT) pc_q <= take_branch ? target : pc_q + AW'(1);
        end
        S_WB:    regs[wb_addr] <= wb_data;
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign flag_zero  = z_q;
  assign flag_carry = c_q;

endmodule

// File: tb/tb_cpu_core_p.sv
// Bench for cpu_core_p: an 8-bit/16-register core and a 16-bit/8-register
// core with RESET_PC=0xFF, each behind its own behavioural instruction memory.
module tb_cpu_core_p;
  localparam int AW = 8;
  localparam int IW = 24;   // DW=8,  NREG=16
  localparam int IW2 = 29;  // DW=16, NREG=8

  localparam logic [3:0] O_NOP = 4'h0, O_ADD = 4'h1, O_SUB = 4'h2, O_AND = 4'h3;
  localparam logic [3:0] O_OR = 4'h4, O_XOR = 4'h5, O_SHL = 4'h6, O_SHR = 4'h7;
  localparam logic [3:0] O_LDI = 4'h8, O_ADDI = 4'h9, O_MOV = 4'hA, O_CMP = 4'hB;
  localparam logic [3:0] O_BZ = 4'hC, O_BC = 4'hD, O_HLT = 4'hE, O_JMP = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---- core 1 ----
  logic rst = 1'b0;
  logic imem_req, imem_ack = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic wb_valid, flag_zero, flag_carry, halted;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;
  logic [AW-1:0] pc;

  cpu_core_p #(.DW(8), .NREG(16), .AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .halted(halted), .pc(pc));

  // ---- core 2 ----
  logic rst2 = 1'b0;
  logic imem_req2, imem_ack2 = 1'b0;
  logic [AW-1:0] imem_addr2;
  logic [IW2-1:0] imem_rdata2 = '0;
  logic wb_valid2, flag_zero2, flag_carry2, halted2;
  logic [2:0] wb_addr2;
  logic [15:0] wb_data2;
  logic [AW-1:0] pc2;

  cpu_core_p #(.DW(16), .NREG(8), .AW(8), .RESET_PC(8'hFF)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .wb_valid(wb_valid2),
    .wb_addr(wb_addr2), .wb_data(wb_data2), .flag_zero(flag_zero2),
    .flag_carry(flag_carry2), .halted(halted2), .pc(pc2));

  function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [3:0] rd,
                                        input logic [7:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction

  function automatic logic [IW2-1:0] enc2(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [2:0] rd,
                                          input logic [15:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction

  // ---- memory models ----
  logic [IW-1:0]  imem1 [256];
  logic [IW2-1:0] imem2 [256];
  int wait_n = 0, mem_cnt = 0, stab_err = 0;
  bit spur_en = 1'b0, force_ack = 1'b0, hold_pend = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [IW-1:0] junk;
  initial junk = {O_LDI, 4'd0, 4'd0, 4'd5, 8'hAA};

  always @(negedge clk) begin
    if (hold_pend && (imem_req !== 1'b1 || imem_addr !== hold_addr)) stab_err++;
    hold_pend = 1'b0;
    if (force_ack) begin
      imem_ack = 1'b1; imem_rdata = junk;
    end else if (imem_req === 1'b1) begin
      if (mem_cnt >= wait_n) begin
        imem_ack = 1'b1; imem_rdata = imem1[imem_addr]; mem_cnt = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = junk; mem_cnt++;
        hold_pend = 1'b1; hold_addr = imem_addr;
      end
    end else begin
      mem_cnt = 0; imem_ack = spur_en; imem_rdata = junk;
    end
  end

  always @(negedge clk) begin
    imem_ack2 = (imem_req2 === 1'b1);
    imem_rdata2 = imem2[imem_addr2];
  end

  // ---- write-back monitors ----
  logic [11:0] exp_q [$];
  logic [11:0] got_q [$];
  int          got_cyc [$];
  logic [20:0] got2_q [$];

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      got_q.push_back({wb_addr, wb_data});
      got_cyc.push_back(cyc);
    end
    if (wb_valid2 === 1'b1) got2_q.push_back({flag_zero2, flag_carry2, wb_addr2, wb_data2});
  end

  // Reset core 1, release it and count cycles until halted (bounded).
  task automatic run1(input int wn, output int ncyc);
    wait_n = wn;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got_q.delete(); got_cyc.delete();
    @(negedge clk) rst = 1'b1;
    ncyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1; ncyc++;
      if (halted === 1'b1) break;
    end
  endtask

  // Instruction-level reference for core 1: per-instruction cost is
  // fetch (1 + wn) + decode + exec, plus one more for a register write.
  task automatic model1(input int wn, output int ncyc, output logic mz, output logic mc,
                        output int mpc);
    int r [16];
    int pcv, a, b, res, sh, op, rs, rt, rd, imm;
    bit z, c, nc, wr, fl;
    logic [IW-1:0] ins;
    for (int i = 0; i < 16; i++) r[i] = 0;
    pcv = 0; z = 0; c = 0; ncyc = 1;
    exp_q.delete();
    for (int step = 0; step < 500; step++) begin
      ins = imem1[pcv];
      op = int'(ins[23:20]); rs = int'(ins[19:16]); rt = int'(ins[15:12]);
      rd = int'(ins[11:8]); imm = int'(ins[7:0]);
      a = r[rs]; b = r[rt]; sh = imm % 8;
      ncyc += 3 + wn;
      if (op == 14) break;
      res = 0; nc = 0; wr = 0; fl = 0;
      case (op)
        1:  begin res = (a + b) % 256; nc = (a + b) > 255; wr = 1; fl = 1; end
        2:  begin res = (a - b + 256) % 256; nc = a < b; wr = 1; fl = 1; end
        3:  begin res = a & b; wr = 1; fl = 1; end
        4:  begin res = a | b; wr = 1; fl = 1; end
        5:  begin res = a ^ b; wr = 1; fl = 1; end
        6:  begin res = (a * (1 << sh)) % 256; wr = 1; fl = 1; end
        7:  begin res = a / (1 << sh); wr = 1; fl = 1; end
        8:  begin res = imm; wr = 1; end
        9:  begin res = (a + imm) % 256; nc = (a + imm) > 255; wr = 1; fl = 1; end
        10: begin res = a; wr = 1; end
        11: begin res = (a - b + 256) % 256; nc = a < b; fl = 1; end
        default: ;
      endcase
      if (fl) begin z = (res == 0); c = nc; end
      if (wr) begin
        r[rd] = res;
        exp_q.push_back({4'(rd), 8'(res)});
        ncyc += 1;
      end
      if ((op == 12 && z) || (op == 13 && c) || op == 15) pcv = imm;
      else pcv = (pcv + 1) % 256;
    end
    mz = z; mc = c; mpc = pcv;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) imem1[i] = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    vec_cnt++; if (wb_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    vec_cnt++; if ({wb_addr, wb_data} !== 12'h000) begin err_cnt++; $display("FAIL reset_wb got=%h exp=000", {wb_addr, wb_data}); end
    vec_cnt++; if ({flag_zero, flag_carry} !== 2'b00) begin err_cnt++; $display("FAIL reset_flags got=%b exp=00", {flag_zero, flag_carry}); end
    vec_cnt++; if (halted !== 1'b0) begin err_cnt++; $display("FAIL reset_halted got=%b exp=0", halted); end
    vec_cnt++; if (pc !== 8'h00) begin err_cnt++; $display("FAIL reset_pc got=%h exp=00", pc); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      begin err_cnt++; $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=00", imem_req, imem_addr); end
  endtask

  task automatic test_alu_prog();
    int n;
    logic [11:0] e [3];
    for (int i = 0; i < 256; i++) imem1[i] = enc(O_HLT, 0, 0, 0, 0);
    imem1[0] = enc(O_LDI, 0, 0, 1, 8'd200);
    imem1[1] = enc(O_LDI, 0, 0, 2, 8'd100);
    imem1[2] = enc(O_ADD, 1, 2, 3, 8'd0);
    e[0] = {4'd1, 8'd200}; e[1] = {4'd2, 8'd100}; e[2] = {4'd3, 8'd44};
    run1(0, n);
    vec_cnt++; if (got_q.size() !== 3) begin err_cnt++; $display("FAIL alu_wb_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      vec_cnt++; if (got_q[i] !== e[i]) begin err_cnt++; $display("FAIL alu_wb[%0d] got=%h exp=%h", i, got_q[i], e[i]); end
    end
    for (int i = 1; i < 3 && i < got_cyc.size(); i++) begin
      vec_cnt++; if (got_cyc[i] - got_cyc[i-1] !== 4)
        begin err_cnt++; $display("FAIL alu_spacing[%0d] got=%0d exp=4", i, got_cyc[i] - got_cyc[i-1]); end
    end
    vec_cnt++; if ({flag_zero, flag_carry} !== 2'b01) begin err_cnt++; $display("FAIL alu_flags got=%b exp=01", {flag_zero, flag_carry}); end
    vec_cnt++; if (n !== 16 || halted !== 1'b1) begin err_cnt++; $display("FAIL alu_cycles got=%0d halted=%b exp=16", n, halted); end
    vec_cnt++; if (pc !== 8'h03) begin err_cnt++; $display("FAIL alu_halt_pc got=%h exp=03", pc); end
  endtask

  task automatic test_cmp_bz();
    int n;
    for (int v = 5; v <= 6; v++) begin
      for (int i = 0; i < 256; i++) imem1[i] = enc(O_HLT, 0, 0, 0, 0);
      imem1[0] = enc(O_LDI, 0, 0, 1, 8'd5);
      imem1[1] = enc(O_LDI, 0, 0, 2, 8'(v));
      imem1[2] = enc(O_CMP, 1, 2, 7, 8'd0);
      imem1[3] = enc(O_BZ, 0, 0, 0, 8'h20);
      run1(0, n);
      vec_cnt++; if (got_q.size() !== 2) begin err_cnt++; $display("FAIL cmp_wb_count v=%0d got=%0d exp=2", v, got_q.size()); end
      vec_cnt++; if ({flag_zero, flag_carry} !== ((v == 5) ? 2'b10 : 2'b01))
        begin err_cnt++; $display("FAIL cmp_flags v=%0d got=%b exp=%b", v, {flag_zero, flag_carry}, (v == 5) ? 2'b10 : 2'b01); end
      vec_cnt++; if (pc !== ((v == 5) ? 8'h20 : 8'h04))
        begin err_cnt++; $display("FAIL bz_target v=%0d got=%h exp=%h", v, pc, (v == 5) ? 8'h20 : 8'h04); end
      vec_cnt++; if (n !== 18) begin err_cnt++; $display("FAIL cmp_cycles v=%0d got=%0d exp=18", v, n); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    for (int i = 0; i < 256; i++) imem1[i] = enc(O_HLT, 0, 0, 0, 0);
    imem1[0] = enc(O_LDI, 0, 0, 4, 8'h33);
    wait_n = 6;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if ({flag_zero, flag_carry, halted, pc} !== 11'h0)
      begin err_cnt++; $display("FAIL reset_clears got z=%b c=%b h=%b pc=%h exp all 0", flag_zero, flag_carry, halted, pc); end
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL wait_req got=%b exp=1", imem_req); end
    force_ack = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (imem_req !== 1'b0 || pc !== 8'h00)
      begin err_cnt++; $display("FAIL midfetch_reset got req=%b pc=%h exp req=0 pc=00", imem_req, pc); end
    force_ack = 1'b0;
    wait_n = 0;
    got_q.delete(); got_cyc.delete();
    @(negedge clk) rst = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1; n++;
      if (halted === 1'b1) break;
    end
    vec_cnt++; if (got_q.size() !== 1 || got_q[0] !== {4'd4, 8'h33})
      begin err_cnt++; $display("FAIL after_reset_wb got n=%0d first=%h exp n=1 first=433", got_q.size(), (got_q.size() > 0) ? got_q[0] : 12'h0); end
    vec_cnt++; if (n !== 8 || pc !== 8'h01) begin err_cnt++; $display("FAIL after_reset_run got cyc=%0d pc=%h exp 8/01", n, pc); end
  endtask

  task automatic test_wait_states();
    int n;
    logic [11:0] e [3];
    for (int i = 0; i < 256; i++) imem1[i] = enc(O_HLT, 0, 0, 0, 0);
    imem1[0] = enc(O_LDI, 0, 0, 1, 8'd7);
    imem1[1] = enc(O_LDI, 0, 0, 2, 8'd9);
    imem1[2] = enc(O_ADD, 1, 2, 3, 8'd0);
    e[0] = {4'd1, 8'd7}; e[1] = {4'd2, 8'd9}; e[2] = {4'd3, 8'd16};
    spur_en = 1'b1;
    stab_err = 0;
    run1(3, n);
    spur_en = 1'b0;
    vec_cnt++; if (got_q.size() !== 3) begin err_cnt++; $display("FAIL ws_wb_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      vec_cnt++; if (got_q[i] !== e[i]) begin err_cnt++; $display("FAIL ws_wb[%0d] got=%h exp=%h", i, got_q[i], e[i]); end
    end
    for (int i = 1; i < 3 && i < got_cyc.size(); i++) begin
      vec_cnt++; if (got_cyc[i] - got_cyc[i-1] !== 7)
        begin err_cnt++; $display("FAIL ws_spacing[%0d] got=%0d exp=7", i, got_cyc[i] - got_cyc[i-1]); end
    end
    vec_cnt++; if (stab_err !== 0) begin err_cnt++; $display("FAIL ws_req_stable got=%0d exp=0", stab_err); end
    vec_cnt++; if (n !== 28) begin err_cnt++; $display("FAIL ws_cycles got=%0d exp=28", n); end
  endtask

  task automatic test_random();
    int n, ecyc, epc, wn;
    logic ez, ec;
    logic [3:0] op;
    logic [7:0] imm;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 256; i++) imem1[i] = enc(O_HLT, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++)
        imem1[k] = enc(O_LDI, 0, 0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      for (int k = 4; k < 14; k++) begin
        op = 4'($urandom_range(0, 14));
        if (op == O_HLT) op = O_JMP;
        imm = (op == O_BZ || op == O_BC || op == O_JMP) ? 8'(k + 2) : 8'($urandom_range(0, 255));
        imem1[k] = enc(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), imm);
      end
      wn = $urandom_range(0, 2);
      model1(wn, ecyc, ez, ec, epc);
      run1(wn, n);
      vec_cnt++; if (got_q.size() !== exp_q.size())
        begin err_cnt++; $display("FAIL rnd%0d_wb_count got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        vec_cnt++; if (got_q[i] !== exp_q[i])
          begin err_cnt++; $display("FAIL rnd%0d_wb[%0d] got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
      end
      vec_cnt++; if ({flag_zero, flag_carry} !== {ez, ec})
        begin err_cnt++; $display("FAIL rnd%0d_flags got=%b exp=%b", it, {flag_zero, flag_carry}, {ez, ec}); end
      vec_cnt++; if (pc !== 8'(epc) || n !== ecyc)
        begin err_cnt++; $display("FAIL rnd%0d_pc_cycles got=%h/%0d exp=%h/%0d", it, pc, n, 8'(epc), ecyc); end
    end
  endtask

  task automatic test_halt_wrap();
    int n, bad;
    for (int i = 0; i < 256; i++) imem2[i] = enc2(O_HLT, 0, 0, 0, 0);
    imem2[8'hFF] = enc2(O_NOP, 0, 0, 0, 0);
    @(negedge clk) rst2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst2 = 1'b1;
    @(posedge clk); #1;
    n = 1;
    vec_cnt++; if (imem_req2 !== 1'b1 || imem_addr2 !== 8'hFF)
      begin err_cnt++; $display("FAIL p2_first_fetch got req=%b addr=%h exp 1/ff", imem_req2, imem_addr2); end
    for (int i = 0; i < 200 && halted2 !== 1'b1; i++) begin
      @(posedge clk); #1; n++;
    end
    vec_cnt++; if (halted2 !== 1'b1 || pc2 !== 8'h00 || n !== 7)
      begin err_cnt++; $display("FAIL wrap_halt got h=%b pc=%h cyc=%0d exp 1/00/7", halted2, pc2, n); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (imem_req2 !== 1'b0 || halted2 !== 1'b1 || pc2 !== 8'h00) bad++;
    end
    vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL halt_stays got=%0d bad cycles exp=0", bad); end
    @(negedge clk) rst2 = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (halted2 !== 1'b0 || pc2 !== 8'hFF)
      begin err_cnt++; $display("FAIL halt_recover got h=%b pc=%h exp 0/ff", halted2, pc2); end
  endtask

  task automatic test_param();
    int n;
    logic [20:0] e [4];
    for (int i = 0; i < 256; i++) imem2[i] = enc2(O_HLT, 0, 0, 0, 0);
    imem2[8'hFF] = enc2(O_LDI, 0, 0, 0, 16'h0001);
    imem2[8'h00] = enc2(O_ADDI, 0, 0, 0, 16'hFFFF);
    imem2[8'h01] = enc2(O_LDI, 0, 0, 1, 16'h0005);
    imem2[8'h02] = enc2(O_SHL, 1, 0, 2, 16'h0013);
    e[0] = {2'b00, 3'd0, 16'h0001};
    e[1] = {2'b11, 3'd0, 16'h0000};
    e[2] = {2'b11, 3'd1, 16'h0005};
    e[3] = {2'b00, 3'd2, 16'h0028};
    rst2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 got2_q.delete();
    @(negedge clk) rst2 = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1; n++;
      if (halted2 === 1'b1) break;
    end
    vec_cnt++; if (got2_q.size() !== 4) begin err_cnt++; $display("FAIL p2_wb_count got=%0d exp=4", got2_q.size()); end
    for (int i = 0; i < 4 && i < got2_q.size(); i++) begin
      vec_cnt++; if (got2_q[i] !== e[i]) begin err_cnt++; $display("FAIL p2_wb[%0d] got=%h exp=%h", i, got2_q[i], e[i]); end
    end
    vec_cnt++; if (n !== 20 || pc2 !== 8'h03)
      begin err_cnt++; $display("FAIL p2_cycles got=%0d pc=%h exp 20/03", n, pc2); end
  endtask

  initial begin
    test_reset();
    test_alu_prog();
    test_cmp_bz();
    test_mid_reset();
    test_wait_states();
    test_random();
    test_halt_wrap();
    test_param();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
